// File: rtl/comp2_serial_dec.sv
// rtl/comp2_serial_dec.sv - bit-serial two's-complement to sign-magnitude decoder (LSB first).
// Optional build macro COMP2_DEC_SAT_EN saturates the magnitude of -2^(WIDTH-1).
module comp2_serial_dec #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             busy,
   output logic             out_valid,
   output logic             out_sign,
   output logic [WIDTH-2:0] out_mag,
   output logic             ovf
);

   localparam int MW = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            seen_q, seen_d;
   logic [MW-1:0]   raw_q, raw_d;
   logic [MW-1:0]   neg_q, neg_d;
   logic            out_valid_q, out_valid_d;
   logic            out_sign_q, out_sign_d;
   logic [MW-1:0]   out_mag_q, out_mag_d;
   logic            ovf_q, ovf_d;
   logic            seen_cur;
   logic            neg_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         seen_q      <= 1'b0;
         raw_q       <= '0;
         neg_q       <= '0;
         out_valid_q <= 1'b0;
         out_sign_q  <= 1'b0;
         out_mag_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         raw_q       <= raw_d;
         neg_q       <= neg_d;
         out_valid_q <= out_valid_d;
         out_sign_q  <= out_sign_d;
         out_mag_q   <= out_mag_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      raw_d       = raw_q;
      neg_d       = neg_q;
      out_valid_d = 1'b0;
      out_sign_d  = out_sign_q;
      out_mag_d   = out_mag_q;
      ovf_d       = ovf_q;

      // A new word always starts with seen_one cleared, whatever the register holds.
      seen_cur = (state_q == SHIFT) ? seen_q : 1'b0;
      neg_bit  = in_bit ^ seen_cur;

      if (in_valid) begin
         if (state_q == SHIFT && cnt_q == CW'(WIDTH - 1)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            seen_d      = 1'b0;
            out_valid_d = 1'b1;
            out_sign_d  = in_bit;
            ovf_d       = in_bit & (raw_q == '0);
            if (!in_bit) begin
               out_mag_d = raw_q;
            end else if (raw_q == '0) begin
`ifdef COMP2_DEC_SAT_EN
               out_mag_d = '1;
`else
               out_mag_d = '0;
`endif
            end else begin
               out_mag_d = neg_q;
            end
         end else begin
            state_d = SHIFT;
            cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
            seen_d  = seen_cur | in_bit;
            // Bits enter at the top so that after WIDTH-1 shifts bit 0 sits at index 0.
            raw_d   = (raw_q >> 1) | (MW'(in_bit) << (MW - 1));
            neg_d   = (neg_q >> 1) | (MW'(neg_bit) << (MW - 1));
         end
      end
   end

   assign busy      = (state_q == SHIFT);
   assign out_valid = out_valid_q;
   assign out_sign  = out_sign_q;
   assign out_mag   = out_mag_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_comp2_serial_dec.sv
// tb/tb_comp2_serial_dec.sv - directed self-checking bench for comp2_serial_dec (WIDTH=4).
module tb_comp2_serial_dec;

   localparam int W = 4;

`ifdef COMP2_DEC_SAT_EN
   localparam logic [2:0] OVF_MAG = 3'b111;
`else
   localparam logic [2:0] OVF_MAG = 3'b000;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_bit;
   logic         busy;
   logic         out_valid;
   logic         out_sign;
   logic [W-2:0] out_mag;
   logic         ovf;

   int vectors;
   int miscompares;

   comp2_serial_dec #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .busy      (busy),
      .out_valid (out_valid),
      .out_sign  (out_sign),
      .out_mag   (out_mag),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
      chk({tag, ".out_valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, ".out_sign"}, {7'd0, out_sign}, 8'd0);
      chk({tag, ".out_mag"}, {5'd0, out_mag}, 8'd0);
      chk({tag, ".ovf"}, {7'd0, ovf}, 8'd0);
   endtask

   // w is the word value; bit w[i] is sent in position i (LSB first).
   task automatic send_word(input string tag, input logic [3:0] w, input int gap,
                            input logic e_sign, input logic [2:0] e_mag, input logic e_ovf);
      for (int i = 0; i < W; i++) begin
         in_valid = 1'b1;
         in_bit   = w[i];
         tick();
         if (i < W - 1) begin
            chk({tag, ".busy"}, {7'd0, busy}, 8'd1);
            chk({tag, ".no_pulse"}, {7'd0, out_valid}, 8'd0);
            for (int g = 0; g < gap; g++) begin
               in_valid = 1'b0;
               in_bit   = 1'b0;
               tick();
               chk({tag, ".gap_busy"}, {7'd0, busy}, 8'd1);
               chk({tag, ".gap_no_pulse"}, {7'd0, out_valid}, 8'd0);
            end
         end
      end
      chk({tag, ".out_valid"}, {7'd0, out_valid}, 8'd1);
      chk({tag, ".busy_done"}, {7'd0, busy}, 8'd0);
      chk({tag, ".sign"}, {7'd0, out_sign}, {7'd0, e_sign});
      chk({tag, ".mag"}, {5'd0, out_mag}, {5'd0, e_mag});
      chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, e_ovf});
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   initial begin
      int          sv;
      int          absval;
      logic        e_sign;
      logic        e_ovf;
      logic [2:0]  e_mag;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_bit      = 1'b0;

      // 1. reset and idle
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_all_zero("idle");
      end

      // 2. +5, then one idle cycle: pulse drops, result holds
      send_word("pos5", 4'b0101, 0, 1'b0, 3'b101, 1'b0);
      tick();
      chk("pos5.pulse_end", {7'd0, out_valid}, 8'd0);
      chk("pos5.mag_hold", {5'd0, out_mag}, 8'h05);

      // 3. -5 then -1 back to back
      send_word("neg5", 4'b1011, 0, 1'b1, 3'b101, 1'b0);
      send_word("neg1", 4'b1111, 0, 1'b1, 3'b001, 1'b0);
      tick();

      // 4. -8 overflow
      send_word("neg8", 4'b1000, 0, 1'b1, OVF_MAG, 1'b1);
      tick();

      // 5. -3 with 2-cycle gaps between bits
      send_word("neg3_gap", 4'b1101, 2, 1'b1, 3'b011, 1'b0);
      tick();
      chk("neg3_gap.single_pulse", {7'd0, out_valid}, 8'd0);

      // 6. reset mid-word, then +2
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
      tick();
      chk("abort.busy", {7'd0, busy}, 8'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort.reset");
      in_valid = 1'b0;
      in_bit   = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk_all_zero("abort.after");
      send_word("pos2", 4'b0010, 0, 1'b0, 3'b010, 1'b0);
      tick();

      // exhaustive sweep, back to back
      for (int v = 0; v < 16; v++) begin
         sv     = (v >= 8) ? v - 16 : v;
         e_sign = (sv < 0);
         absval = (sv < 0) ? -sv : sv;
         e_ovf  = (absval == 8);
         e_mag  = e_ovf ? OVF_MAG : 3'(absval);
         send_word($sformatf("sweep%0d", v), 4'(v), 0, e_sign, e_mag, e_ovf);
      end
      tick();
      chk("sweep.end_pulse", {7'd0, out_valid}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
